// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants, piece/FSM types and cell address helper
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam int ADDR_W  = 8;

  typedef enum logic [2:0] {
    SHAPE_I, SHAPE_J, SHAPE_L, SHAPE_Z, SHAPE_S, SHAPE_T, SHAPE_O
  } shape_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_CHECK = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [2:0] cell_colour_t;

  typedef struct packed {
    logic              oob;
    logic [ADDR_W-1:0] addr;
  } cell_ref_t;

  // Sums are 6 bits wide so an origin near the edge cannot wrap back into the board.
  function automatic cell_ref_t cell_ref(
    input logic [3:0] ox,
    input logic [4:0] oy,
    input logic [1:0] dx,
    input logic [1:0] dy,
    input int         bw,
    input int         bh
  );
    logic [5:0] ax;
    logic [5:0] ay;
    cell_ref_t  r;
    ax     = {2'b00, ox} + {4'b0000, dx};
    ay     = {1'b0, oy} + {4'b0000, dy};
    r.oob  = (ax >= 6'(bw)) || (ay >= 6'(bh));
    r.addr = ADDR_W'(ay) * ADDR_W'(bw) + ADDR_W'(ax);
    return r;
  endfunction

endpackage

// File: rtl/shapeROM.sv
// rtl/shapeROM.sv - cell offsets (x,y in 0..3) of the four cells for each shape and rotation
module shapeROM
  import tetris_pkg::*;
(
  input  logic [2:0]      shape_index,
  input  logic [1:0]      rotation_index,
  output logic [3:0][1:0] off_x,
  output logic [3:0][1:0] off_y
);

  // One nibble per cell, cell 0 in the low nibble; nibble = {y, x}.
  logic [15:0] cells;

  always_comb begin
    cells = 16'h0000;
    case (shape_index)
      SHAPE_I: cells = rotation_index[0] ? 16'hC840 : 16'h3210;
      SHAPE_J: case (rotation_index)
                 2'd0: cells = 16'h6540;
                 2'd1: cells = 16'h8410;
                 2'd2: cells = 16'h6210;
                 default: cells = 16'h9851;
               endcase
      SHAPE_L: case (rotation_index)
                 2'd0: cells = 16'h6542;
                 2'd1: cells = 16'h9840;
                 2'd2: cells = 16'h4210;
                 default: cells = 16'h9510;
               endcase
      SHAPE_Z: cells = rotation_index[0] ? 16'h8541 : 16'h6510;
      SHAPE_S: cells = rotation_index[0] ? 16'h9540 : 16'h5421;
      SHAPE_T: case (rotation_index)
                 2'd0: cells = 16'h5210;
                 2'd1: cells = 16'h9541;
                 2'd2: cells = 16'h6541;
                 default: cells = 16'h8540;
               endcase
      SHAPE_O: cells = 16'h5410;
      default: cells = 16'h0000;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      off_x[i] = cells[4*i +: 2];
      off_y[i] = cells[4*i+2 +: 2];
    end
  end

endmodule

// File: rtl/piece_collision_check.sv
// rtl/piece_collision_check.sv - probes the playfield for a piece's four cells and optionally stamps them
module piece_collision_check #(
  parameter int BOARD_W = tetris_pkg::BOARD_W,
  parameter int BOARD_H = tetris_pkg::BOARD_H,
  parameter int ADDR_W  = tetris_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              commit,
  input  logic [2:0]        shape_index,
  input  logic [1:0]        rotation_index,
  input  logic [3:0]        origin_x,
  input  logic [4:0]        origin_y,
  output logic [ADDR_W-1:0] brd_addr,
  input  logic [2:0]        brd_rd_data,
  output logic              brd_we,
  output logic [2:0]        brd_wr_data,
  output logic              busy,
  output logic              done,
  output logic              collision,
  output logic              committed
);
  import tetris_pkg::*;

  state_t            state;
  logic [1:0]        k;
  logic [2:0]        shape_q;
  logic [1:0]        rot_q;
  logic [3:0]        ox_q;
  logic [4:0]        oy_q;
  logic              commit_q;
  logic [ADDR_W-1:0] addr_hold;
  logic              prev_chk;
  logic [3:0][1:0]   off_x;
  logic [3:0][1:0]   off_y;
  cell_ref_t         cur;
  logic              cur_oob;
  logic              hit;
  logic              coll_next;

  shapeROM u_rom (
    .shape_index    (shape_q),
    .rotation_index (rot_q),
    .off_x          (off_x),
    .off_y          (off_y)
  );

  always_comb begin
    cur      = cell_ref(ox_q, oy_q, off_x[k], off_y[k], BOARD_W, BOARD_H);
    // An invalid shape is handled as four out-of-bounds cells: no reads, forced collision.
    cur_oob  = cur.oob || (shape_q == 3'd7);
    brd_addr = addr_hold;
    if ((state == ST_READ && !cur_oob) || state == ST_WRITE)
      brd_addr = ADDR_W'(cur.addr);
    hit       = prev_chk && (brd_rd_data != 3'd0);
    coll_next = collision || hit || (state == ST_READ && cur_oob);
    busy      = (state == ST_READ) || (state == ST_CHECK) || (state == ST_WRITE);
    done      = (state == ST_DONE);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      k           <= 2'd0;
      shape_q     <= 3'd0;
      rot_q       <= 2'd0;
      ox_q        <= 4'd0;
      oy_q        <= 5'd0;
      commit_q    <= 1'b0;
      addr_hold   <= '0;
      prev_chk    <= 1'b0;
      brd_we      <= 1'b0;
      brd_wr_data <= 3'd0;
      collision   <= 1'b0;
      committed   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          shape_q     <= shape_index;
          rot_q       <= rotation_index;
          ox_q        <= origin_x;
          oy_q        <= origin_y;
          commit_q    <= commit;
          collision   <= 1'b0;
          committed   <= 1'b0;
          prev_chk    <= 1'b0;
          k           <= 2'd0;
          brd_wr_data <= shape_index + 3'd1;
          state       <= ST_READ;
        end
        ST_READ: begin
          collision <= coll_next;
          prev_chk  <= !cur_oob;
          addr_hold <= brd_addr;
          k         <= k + 2'd1;
          if (k == 2'd3) state <= ST_CHECK;
        end
        ST_CHECK: begin
          collision <= coll_next;
          prev_chk  <= 1'b0;
          k         <= 2'd0;
          if (commit_q && !coll_next) begin
            brd_we <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          addr_hold <= brd_addr;
          k         <= k + 2'd1;
          if (k == 2'd3) begin
            brd_we    <= 1'b0;
            committed <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piece_collision_check.sv
// tb/tb_piece_collision_check.sv - directed bench with a behavioural playfield RAM
module tb_piece_collision_check;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic       commit = 1'b0;
  logic [2:0] shape_index = 3'd0;
  logic [1:0] rotation_index = 2'd0;
  logic [3:0] origin_x = 4'd0;
  logic [4:0] origin_y = 5'd0;
  logic [7:0] brd_addr;
  logic [2:0] brd_rd_data;
  logic       brd_we;
  logic [2:0] brd_wr_data;
  logic       busy, done, collision, committed;

  logic [2:0] mem [0:255] = '{default: 3'd0};
  logic [2:0] rd_q = 3'd0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'd0;
  logic [2:0] poke_data = 3'd0;
  logic [7:0] wq_addr [$];
  logic [2:0] wq_data [$];

  int checks = 0;
  int failures = 0;
  int done_cyc, done_cnt, addr_changes;
  bit saw10;

  always #5 Clk = ~Clk;
  assign brd_rd_data = rd_q;

  always @(posedge Clk) begin
    rd_q <= mem[brd_addr];
    if (brd_we) begin
      mem[brd_addr] <= brd_wr_data;
      wq_addr.push_back(brd_addr);
      wq_data.push_back(brd_wr_data);
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  piece_collision_check dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .start          (start),
    .commit         (commit),
    .shape_index    (shape_index),
    .rotation_index (rotation_index),
    .origin_x       (origin_x),
    .origin_y       (origin_y),
    .brd_addr       (brd_addr),
    .brd_rd_data    (brd_rd_data),
    .brd_we         (brd_we),
    .brd_wr_data    (brd_wr_data),
    .busy           (busy),
    .done           (done),
    .collision      (collision),
    .committed      (committed)
  );

  // Runs one operation; cycle i counts negedges after the accept edge. inject pulses start mid-op.
  task automatic run_op(input logic [2:0] sh, input logic [1:0] rot, input logic [3:0] ox,
                        input logic [4:0] oy, input logic cm, input bit inject);
    logic [7:0] a0;
    wq_addr.delete();
    wq_data.delete();
    done_cyc = 0; done_cnt = 0; addr_changes = 0; saw10 = 0;
    @(negedge Clk);
    a0 = brd_addr;
    shape_index = sh; rotation_index = rot; origin_x = ox; origin_y = oy; commit = cm;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge Clk);
      if (inject && i == 3) begin
        start = 1'b1; shape_index = 3'd6; commit = 1'b1; origin_x = 4'd0; origin_y = 5'd10;
      end
      if (inject && i == 4) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = i;
      end
      if (busy && brd_addr == 8'd10) saw10 = 1;
      if (brd_addr != a0) addr_changes++;
      a0 = brd_addr;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checks++; if (brd_addr !== 8'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", brd_addr); end
    checks++; if (brd_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", brd_we); end
    checks++; if (brd_wr_data !== 3'd0) begin failures++; $display("FAIL reset_wr_data got=%0d exp=0", brd_wr_data); end
    checks++; if ({busy, done, collision, committed} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {busy, done, collision, committed});
    end
    Reset = 1'b0;
  endtask

  task automatic test_probe_clean;
    run_op(3'd5, 2'd0, 4'd4, 5'd0, 1'b0, 0);
    checks++; if (done_cyc != 6 || done_cnt != 1) begin failures++; $display("FAIL probe_done_cycle got=%0d/%0d exp=6/1", done_cyc, done_cnt); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL probe_collision got=%b exp=0", collision); end
    checks++; if (wq_addr.size() != 0) begin failures++; $display("FAIL probe_writes got=%0d exp=0", wq_addr.size()); end
  endtask

  task automatic test_commit;
    logic [7:0] exp_a [4] = '{8'd184, 8'd185, 8'd194, 8'd195};
    run_op(3'd6, 2'd0, 4'd4, 5'd18, 1'b1, 0);
    checks++; if (done_cyc != 10) begin failures++; $display("FAIL commit_done_cycle got=%0d exp=10", done_cyc); end
    checks++; if (committed !== 1'b1 || collision !== 1'b0) begin
      failures++; $display("FAIL commit_flags got=%b%b exp=10", committed, collision);
    end
    checks++;
    if (wq_addr.size() != 4) begin
      failures++; $display("FAIL commit_write_count got=%0d exp=4", wq_addr.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (wq_addr[i] != exp_a[i] || wq_data[i] != 3'd7) begin
          failures++;
          $display("FAIL commit_write%0d got=%0d:%0d exp=%0d:7", i, wq_addr[i], wq_data[i], exp_a[i]);
          break;
        end
    end
    checks++; if (mem[195] !== 3'd7) begin failures++; $display("FAIL commit_mem195 got=%0d exp=7", mem[195]); end
  endtask

  task automatic test_occupied;
    @(negedge Clk);
    poke_en = 1'b1; poke_addr = 8'd55; poke_data = 3'd2;
    @(negedge Clk);
    poke_en = 1'b0;
    run_op(3'd0, 2'd0, 4'd3, 5'd5, 1'b1, 0);
    checks++; if (collision !== 1'b1 || committed !== 1'b0) begin
      failures++; $display("FAIL occupied_flags got=%b%b exp=10", collision, committed);
    end
    checks++; if (wq_addr.size() != 0 || done_cyc != 6) begin
      failures++; $display("FAIL occupied_writes got=%0d done=%0d exp=0 done=6", wq_addr.size(), done_cyc);
    end
  endtask

  task automatic test_oob;
    run_op(3'd0, 2'd0, 4'd7, 5'd0, 1'b1, 0);
    checks++; if (collision !== 1'b1) begin failures++; $display("FAIL oob_x_collision got=%b exp=1", collision); end
    checks++; if (saw10) begin failures++; $display("FAIL oob_x_addr10 got=issued exp=not_issued"); end
    checks++; if (wq_addr.size() != 0) begin failures++; $display("FAIL oob_x_writes got=%0d exp=0", wq_addr.size()); end
    run_op(3'd0, 2'd1, 4'd0, 5'd17, 1'b1, 0);
    checks++; if (collision !== 1'b1 || committed !== 1'b0) begin
      failures++; $display("FAIL oob_y_flags got=%b%b exp=10", collision, committed);
    end
    checks++; if (wq_addr.size() != 0) begin failures++; $display("FAIL oob_y_writes got=%0d exp=0", wq_addr.size()); end
  endtask

  task automatic test_invalid_shape;
    run_op(3'd7, 2'd0, 4'd2, 5'd2, 1'b1, 0);
    checks++; if (collision !== 1'b1 || done_cyc != 6) begin
      failures++; $display("FAIL invalid_result got=%b done=%0d exp=1 done=6", collision, done_cyc);
    end
    checks++; if (addr_changes != 0 || wq_addr.size() != 0) begin
      failures++; $display("FAIL invalid_activity got=%0d/%0d exp=0/0", addr_changes, wq_addr.size());
    end
  endtask

  task automatic test_reset_in_write;
    wq_addr.delete();
    wq_data.delete();
    @(negedge Clk);
    shape_index = 3'd6; rotation_index = 2'd0; origin_x = 4'd0; origin_y = 5'd0; commit = 1'b1;
    start = 1'b1;
    @(posedge Clk);
    #1 start = 1'b0;
    for (int i = 1; i <= 7; i++) @(negedge Clk);
    checks++; if (brd_we !== 1'b1) begin failures++; $display("FAIL rst_write_pre_we got=%b exp=1", brd_we); end
    Reset = 1'b1;
    #1;
    checks++; if ({brd_we, busy, done, collision, committed} !== 5'b0 || brd_addr !== 8'd0 || brd_wr_data !== 3'd0) begin
      failures++;
      $display("FAIL rst_write_outputs got=%b addr=%0d wd=%0d exp=0",
               {brd_we, busy, done, collision, committed}, brd_addr, brd_wr_data);
    end
    repeat (3) @(negedge Clk);
    checks++; if (wq_addr.size() != 1 || mem[1] !== 3'd0 || mem[0] !== 3'd7) begin
      failures++; $display("FAIL rst_write_mem got=%0d m0=%0d m1=%0d exp=1 m0=7 m1=0", wq_addr.size(), mem[0], mem[1]);
    end
    Reset = 1'b0;
  endtask

  task automatic test_back_to_back;
    run_op(3'd5, 2'd0, 4'd4, 5'd0, 1'b0, 1);
    checks++; if (done_cyc != 6 || done_cnt != 1 || wq_addr.size() != 0) begin
      failures++; $display("FAIL busy_start_ignored got=%0d/%0d/%0d exp=6/1/0", done_cyc, done_cnt, wq_addr.size());
    end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL busy_start_collision got=%b exp=0", collision); end
    run_op(3'd0, 2'd1, 4'd9, 5'd0, 1'b0, 0);
    checks++; if (done_cyc != 6 || collision !== 1'b0) begin
      failures++; $display("FAIL next_start got=%0d/%b exp=6/0", done_cyc, collision);
    end
  endtask

  initial begin
    test_reset;
    test_probe_clean;
    test_commit;
    test_occupied;
    test_oob;
    test_invalid_shape;
    test_reset_in_write;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
